// File: rtl/getir_coz_tamponu.sv
// Fetch-to-decode instruction buffer: a small circular FIFO of {PC, instruction, taken-prediction}.
// The head entry is presented combinationally; a NOP is presented when the buffer is empty.
module getir_coz_tamponu #(
    parameter int          DERINLIK   = 2,
    parameter logic [31:0] BOS_BUYRUK = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        getir_gecerli_i,
    input  logic [31:0] getir_ps_i,
    input  logic [31:0] getir_buyruk_i,
    input  logic        getir_ongoru_i,
    output logic        getir_hazir_o,
    input  logic        temizle_i,
    input  logic        durdur_i,
    output logic        coz_gecerli_o,
    output logic [31:0] coz_ps_o,
    output logic [31:0] coz_buyruk_o,
    output logic        coz_ongoru_o,
    output logic [2:0]  doluluk_o
);

    localparam int             PW      = (DERINLIK > 2) ? 2 : 1;
    localparam logic [PW-1:0]  SON_IDX = PW'(DERINLIK - 1);
    localparam logic [2:0]     DER_W   = 3'(DERINLIK);

    logic [31:0]   ps_mem     [DERINLIK];
    logic [31:0]   buyruk_mem [DERINLIK];
    logic          ongoru_mem [DERINLIK];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    doluluk_q, doluluk_d;

    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == SON_IDX) ? '0 : p + 1'b1;
    endfunction

    assign getir_hazir_o = (doluluk_q < DER_W);
    assign coz_gecerli_o = (doluluk_q != 3'd0);
    assign doluluk_o     = doluluk_q;

    assign push = getir_gecerli_i & getir_hazir_o & ~temizle_i;
    assign pop  = coz_gecerli_o & ~durdur_i & ~temizle_i;

    // Empty buffer shows a NOP so decode never sees stale storage contents.
    assign coz_ps_o     = coz_gecerli_o ? ps_mem[rd_ptr_q]     : 32'd0;
    assign coz_buyruk_o = coz_gecerli_o ? buyruk_mem[rd_ptr_q] : BOS_BUYRUK;
    assign coz_ongoru_o = coz_gecerli_o ? ongoru_mem[rd_ptr_q] : 1'b0;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        doluluk_d = doluluk_q;
        if (temizle_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            doluluk_d = 3'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                doluluk_d = doluluk_q + 3'd1;
            end else if (pop && !push) begin
                doluluk_d = doluluk_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            doluluk_q <= 3'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            doluluk_q <= doluluk_d;
        end
    end

    // Storage is deliberately not reset; the count alone decides what is valid.
    for (genvar gi = 0; gi < DERINLIK; gi++) begin : g_kayit
        always_ff @(posedge clk_i) begin
            if (!rst_i && push && (wr_ptr_q == PW'(gi))) begin
                ps_mem[gi]     <= getir_ps_i;
                buyruk_mem[gi] <= getir_buyruk_i;
                ongoru_mem[gi] <= getir_ongoru_i;
            end
        end
    end

endmodule

// File: tb/tb_getir_coz_tamponu.sv
// Bench for getir_coz_tamponu: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_getir_coz_tamponu;

    localparam int          D   = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        getir_gecerli_i;
    logic [31:0] getir_ps_i;
    logic [31:0] getir_buyruk_i;
    logic        getir_ongoru_i;
    logic        getir_hazir_o;
    logic        temizle_i;
    logic        durdur_i;
    logic        coz_gecerli_o;
    logic [31:0] coz_ps_o;
    logic [31:0] coz_buyruk_o;
    logic        coz_ongoru_o;
    logic [2:0]  doluluk_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [31:0] ps;
        logic [31:0] buyruk;
        logic        ongoru;
    } ent_t;

    ent_t mq[$];
    bit   m_push_last = 1'b0;

    always #5 clk = ~clk;

    getir_coz_tamponu #(.DERINLIK(D), .BOS_BUYRUK(NOP)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .getir_gecerli_i (getir_gecerli_i),
        .getir_ps_i      (getir_ps_i),
        .getir_buyruk_i  (getir_buyruk_i),
        .getir_ongoru_i  (getir_ongoru_i),
        .getir_hazir_o   (getir_hazir_o),
        .temizle_i       (temizle_i),
        .durdur_i        (durdur_i),
        .coz_gecerli_o   (coz_gecerli_o),
        .coz_ps_o        (coz_ps_o),
        .coz_buyruk_o    (coz_buyruk_o),
        .coz_ongoru_o    (coz_ongoru_o),
        .doluluk_o       (doluluk_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered queue bounded by D.
    always @(posedge clk) begin
        bit pu;
        bit po;
        pu = 1'b0;
        po = 1'b0;
        if (rst_i || temizle_i) begin
            mq.delete();
        end else begin
            pu = getir_gecerli_i && (mq.size() < D);
            po = (mq.size() != 0) && !durdur_i;
            if (po) begin
                $display("pop  ps=%h buyruk=%h ongoru=%0d", mq[0].ps, mq[0].buyruk, mq[0].ongoru);
                void'(mq.pop_front());
            end
            if (pu) begin
                mq.push_back('{ps: getir_ps_i, buyruk: getir_buyruk_i, ongoru: getir_ongoru_i});
            end
        end
        m_push_last = pu;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_gecerli", 32'(coz_gecerli_o), 32'(mq.size() != 0));
            chk("m_hazir",   32'(getir_hazir_o), 32'(mq.size() < D));
            chk("m_doluluk", 32'(doluluk_o),     32'(mq.size()));
            chk("m_ps",      coz_ps_o,           (mq.size() != 0) ? mq[0].ps : 32'd0);
            chk("m_buyruk",  coz_buyruk_o,       (mq.size() != 0) ? mq[0].buyruk : NOP);
            chk("m_ongoru",  32'(coz_ongoru_o),  (mq.size() != 0) ? 32'(mq[0].ongoru) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [31:0] ps, input logic [31:0] ins, input logic ong);
        getir_gecerli_i = 1'b1;
        getir_ps_i      = ps;
        getir_buyruk_i  = ins;
        getir_ongoru_i  = ong;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_gecerli"}, 32'(coz_gecerli_o), 32'd0);
        chk({nm, "_buyruk"},  coz_buyruk_o,       NOP);
        chk({nm, "_ps"},      coz_ps_o,           32'd0);
        chk({nm, "_ongoru"},  32'(coz_ongoru_o),  32'd0);
        chk({nm, "_hazir"},   32'(getir_hazir_o), 32'd1);
        chk({nm, "_doluluk"}, 32'(doluluk_o),     32'd0);
    endtask

    initial begin
        rst_i = 1'b1; temizle_i = 1'b0; durdur_i = 1'b0;
        getir_gecerli_i = 1'b0; getir_ps_i = '0; getir_buyruk_i = '0; getir_ongoru_i = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_reset_vals("reset");

        // Single push then immediate drain.
        offer(32'h100, 32'h0050_0093, 1'b0);
        tick();
        getir_gecerli_i = 1'b0;
        chk("one_gecerli", 32'(coz_gecerli_o), 32'd1);
        chk("one_ps",      coz_ps_o,           32'h100);
        chk("one_buyruk",  coz_buyruk_o,       32'h0050_0093);
        tick();
        chk("one_gone_gecerli", 32'(coz_gecerli_o), 32'd0);
        chk("one_gone_buyruk",  coz_buyruk_o,       32'h13);

        // Fill under stall.
        durdur_i = 1'b1;
        offer(32'h100, 32'h1, 1'b0); tick();
        offer(32'h104, 32'h2, 1'b0); tick();
        chk("full_hazir",   32'(getir_hazir_o), 32'd0);
        chk("full_doluluk", 32'(doluluk_o),     32'd2);
        chk("full_head",    coz_ps_o,           32'h100);

        // Release with continuous offers across the pointer wrap.
        durdur_i = 1'b0;
        offer(32'h108, 32'h3, 1'b0);
        tick();
        chk("flow_head1", coz_ps_o, 32'h104);
        chk("flow_dol1",  32'(doluluk_o), 32'd1);
        tick();
        chk("flow_head2", coz_ps_o, 32'h108);
        offer(32'h10C, 32'h4, 1'b0);
        tick();
        chk("flow_head3", coz_ps_o, 32'h10C);
        chk("flow_dol3",  32'(doluluk_o), 32'd1);
        getir_gecerli_i = 1'b0;
        tick();
        chk("flow_empty", 32'(coz_gecerli_o), 32'd0);

        // Flush with a simultaneous offer.
        durdur_i = 1'b1;
        offer(32'h300, 32'h5, 1'b0); tick();
        offer(32'h304, 32'h6, 1'b0); tick();
        temizle_i = 1'b1;
        offer(32'h200, 32'h7, 1'b0);
        tick();
        temizle_i = 1'b0;
        getir_gecerli_i = 1'b0;
        chk("flush_dol",     32'(doluluk_o),     32'd0);
        chk("flush_gecerli", 32'(coz_gecerli_o), 32'd0);
        tick();
        chk("flush_no200", 32'(coz_gecerli_o), 32'd0);

        // Prediction bit follows its entry.
        offer(32'h400, 32'h8, 1'b1); tick();
        offer(32'h404, 32'h9, 1'b0); tick();
        getir_gecerli_i = 1'b0;
        chk("ong_head", 32'(coz_ongoru_o), 32'd1);
        durdur_i = 1'b0;
        tick();
        chk("ong_next",    32'(coz_ongoru_o), 32'd0);
        chk("ong_next_ps", coz_ps_o,          32'h404);
        tick();
        chk("ong_empty", 32'(coz_ongoru_o), 32'd0);

        // Reset beats flush and push.
        durdur_i = 1'b1;
        offer(32'h500, 32'hA, 1'b1); tick();
        rst_i = 1'b1; temizle_i = 1'b1;
        offer(32'h504, 32'hB, 1'b1);
        tick();
        rst_i = 1'b0; temizle_i = 1'b0; getir_gecerli_i = 1'b0; durdur_i = 1'b0;
        chk_reset_vals("rst_mid");

        // Randomized traffic; an unaccepted offer is held unchanged.
        for (int i = 0; i < 3000; i++) begin
            rst_i     = ($urandom_range(0, 199) == 0);
            temizle_i = ($urandom_range(0, 24) == 0);
            durdur_i  = ($urandom_range(0, 2) == 0);
            if (!(getir_gecerli_i && !m_push_last)) begin
                getir_gecerli_i = ($urandom_range(0, 3) != 0);
                getir_ps_i      = $urandom & 32'hFFFF_FFFC;
                getir_buyruk_i  = $urandom;
                getir_ongoru_i  = $urandom_range(0, 1) == 1;
            end
            tick();
        end

        rst_i = 1'b0; temizle_i = 1'b0; getir_gecerli_i = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
